// File: rtl/arythcrypt_pkg.sv
// arythcrypt_pkg: shared definitions for the arythcrypt engine.
//   - opcode encodings for the Control field
//   - FSM state enum
//   - width-parametrised rotate helpers (operate on up to MAX_WIDTH bits;
//     bits at or above 'width' are ignored on input and zero on output)
package arythcrypt_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_ROTL  = 4'd3;
    localparam logic [3:0] OP_ROTR  = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_LDKEY = 4'd6;
    localparam logic [3:0] OP_ENC   = 4'd7;
    localparam logic [3:0] OP_DEC   = 4'd8;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Rotate the low 'width' bits of x left by amt (amt < width).
    function automatic logic [MAX_WIDTH-1:0] rotl_w(input logic [MAX_WIDTH-1:0] x,
                                                    input logic [5:0]           amt,
                                                    input int unsigned          width);
        logic [MAX_WIDTH-1:0] r;
        int unsigned          dst;
        r = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                dst = (i + 32'(amt)) % width;
                r[dst[5:0]] = x[i[5:0]];
            end
        end
        return r;
    endfunction

    // Rotate the low 'width' bits of x right by amt (amt < width).
    function automatic logic [MAX_WIDTH-1:0] rotr_w(input logic [MAX_WIDTH-1:0] x,
                                                    input logic [5:0]           amt,
                                                    input int unsigned          width);
        logic [MAX_WIDTH-1:0] r;
        int unsigned          dst;
        r = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                dst = (i + width - (32'(amt) % width)) % width;
                r[dst[5:0]] = x[i[5:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arythcrypt_round.sv
// arythcrypt_round: combinational cipher round, shared by ENC and DEC.
//   x_i      : current state word
//   key_i    : round key (used unchanged by every round)
//   rc_i     : round constant, zero-extended to WIDTH
//   dir_i    : 0 = forward  x' = rotl1(x + key) ^ rc
//              1 = inverse  x' = rotr1(x ^ rc) - key
//   x_next_o : next state word
module arythcrypt_round #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RCW   = 4
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] key_i,
    input  logic [RCW-1:0]   rc_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] x_next_o
);

    logic [WIDTH-1:0] rc_ext;
    logic [WIDTH-1:0] fwd_sum;
    logic [WIDTH-1:0] inv_mix;

    always_comb begin
        rc_ext  = WIDTH'(rc_i);
        fwd_sum = x_i + key_i;
        inv_mix = x_i ^ rc_ext;
        if (dir_i) begin
            x_next_o = {inv_mix[0], inv_mix[WIDTH-1:1]} - key_i;
        end else begin
            x_next_o = {fwd_sum[WIDTH-2:0], fwd_sum[WIDTH-1]} ^ rc_ext;
        end
    end

endmodule

// File: rtl/arythcrypt_engine.sv
// arythcrypt_engine: arithmetic/crypto datapath with valid/ready handshakes.
//   CLK, Reset         : clock (rising edge) and synchronous active-high reset
//   I1, I2, Control    : request operands and opcode, taken when in_valid & in_ready
//   in_valid/in_ready  : request handshake
//   OUTPUT, err        : result register and reserved-opcode flag
//   out_valid/out_ready: result handshake
//   busy               : ENC/DEC rounds in progress
// Single-cycle ops complete on the accept edge; ENC/DEC run ROUNDS rounds,
// one per cycle, through a single shared round unit.
module arythcrypt_engine
    import arythcrypt_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ROUNDS = 4,
    parameter int unsigned RCW    = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [3:0]       Control,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic             busy
);

    localparam int unsigned  AmtW   = $clog2(WIDTH);
    localparam logic [RCW-1:0] RcLast = RCW'(ROUNDS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [RCW-1:0]   rc_q, rc_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic             accept;
    logic             last_round;
    logic [WIDTH-1:0] round_out;
    logic [AmtW-1:0]  rot_amt;
    logic [WIDTH-1:0] rotl_res;
    logic [WIDTH-1:0] rotr_res;
    logic [WIDTH-1:0] mul_res;

    arythcrypt_round #(
        .WIDTH (WIDTH),
        .RCW   (RCW)
    ) u_round (
        .x_i      (x_q),
        .key_i    (key_q),
        .rc_i     (rc_q),
        .dir_i    (dir_q),
        .x_next_o (round_out)
    );

    always_comb begin
        rot_amt  = I2[AmtW-1:0];
        rotl_res = WIDTH'(rotl_w(MAX_WIDTH'(I1), 6'(rot_amt), WIDTH));
        rotr_res = WIDTH'(rotr_w(MAX_WIDTH'(I1), 6'(rot_amt), WIDTH));
        mul_res  = I1 * I2;
    end

    always_comb begin
        in_ready   = (state_q == StIdle) & (!out_valid_q | out_ready);
        accept     = in_valid & in_ready;
        last_round = dir_q ? (rc_q == '0) : (rc_q == RcLast);

        state_d     = state_q;
        key_d       = key_q;
        x_d         = x_q;
        rc_d        = rc_q;
        dir_d       = dir_q;
        out_d       = out_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;

        // Consumption first; a result written below on the same edge re-sets it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (Control)
                        OP_ADD: begin
                            out_d = I1 + I2;
                            err_d = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        OP_SUB: begin
                            out_d = I1 - I2;
                            err_d = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        OP_XOR: begin
                            out_d = I1 ^ I2;
                            err_d = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        OP_ROTL: begin
                            out_d = rotl_res;
                            err_d = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        OP_ROTR: begin
                            out_d = rotr_res;
                            err_d = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        OP_MUL: begin
                            out_d = mul_res;
                            err_d = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        OP_LDKEY: begin
                            key_d = I2;
                            out_d = I2;
                            err_d = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        OP_ENC: begin
                            x_d     = I1;
                            rc_d    = '0;
                            dir_d   = 1'b0;
                            state_d = StRun;
                        end
                        OP_DEC: begin
                            x_d     = I1;
                            rc_d    = RcLast;
                            dir_d   = 1'b1;
                            state_d = StRun;
                        end
                        default: begin
                            out_d = '0;
                            err_d = 1'b1;
                            out_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            StRun: begin
                x_d = round_out;
                if (last_round) begin
                    out_d       = round_out;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    rc_d = dir_q ? (rc_q - RCW'(1)) : (rc_q + RCW'(1));
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= StIdle;
            key_q       <= '0;
            x_q         <= '0;
            rc_q        <= '0;
            dir_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            x_q         <= x_d;
            rc_q        <= rc_d;
            dir_q       <= dir_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign OUTPUT    = out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_arythcrypt_engine.sv
// Scoreboard bench for arythcrypt_engine (WIDTH=8, ROUNDS=4).
// The driver pushes {err, data} expectations as requests are issued; the
// monitor pops and compares on every out_valid & out_ready transfer.
module tb_arythcrypt_engine;

    logic       clk;
    logic       rst;
    logic [7:0] i1;
    logic [7:0] i2;
    logic [3:0] control;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] result;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       busy;

    int         vectors;
    int         errors;
    logic [8:0] sb[$];
    int         ready_mode;  // 0 hold low, 1 hold high, 2 random

    arythcrypt_engine #(
        .WIDTH  (8),
        .ROUNDS (4),
        .RCW    (4)
    ) dut (
        .CLK       (clk),
        .Reset     (rst),
        .I1        (i1),
        .I2        (i2),
        .Control   (control),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OUTPUT    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] rr1(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    function automatic logic [7:0] enc_model(input logic [7:0] p, input logic [7:0] k);
        logic [7:0] x;
        x = p;
        for (int r = 0; r < 4; r++) x = rl1(x + k) ^ 8'(r);
        return x;
    endfunction

    function automatic logic [7:0] dec_model(input logic [7:0] c, input logic [7:0] k);
        logic [7:0] x;
        x = c;
        for (int r = 3; r >= 0; r--) x = rr1(x ^ 8'(r)) - k;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at posedge+#1 after the accept edge; waits = cycles stalled.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, output int waits);
        sb.push_back(exp);
        control  = op;
        i1       = a;
        i2       = b;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            waits++;
            if (waits > 1000) begin
                vectors++;
                errors++;
                $display("FAIL accept_timeout: op %0d not accepted in %0d cycles", op, waits);
                void'(sb.pop_back());
                @(posedge clk);
                #1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // out_ready owner; updates after the driver so mode changes apply cleanly.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else out_ready = (ready_mode == 1);
        end
    end

    // Monitor: compare transfers against the scoreboard and check stall stability.
    initial begin : monitor
        logic       stalled;
        logic [7:0] prev_data;
        logic       prev_err;
        logic [8:0] exp;
        stalled = 1'b0;
        prev_data = '0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_hold", {22'd0, out_valid, err, result}, {22'd0, 1'b1, prev_err, prev_data});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_result: got 0x%0h err %0b, expected none",
                                 result, err);
                    end else begin
                        exp = sb.pop_front();
                        chk("result", {23'd0, err, result}, {23'd0, exp});
                    end
                end
                stalled   = out_valid && !out_ready;
                prev_data = result;
                prev_err  = err;
            end
        end
    end

    initial begin : driver
        int         w;
        logic [7:0] k;
        logic [7:0] p;
        logic [7:0] c;
        vectors    = 0;
        errors     = 0;
        ready_mode = 1;
        rst        = 1'b1;
        in_valid   = 1'b1;
        control    = 4'd0;
        i1         = 8'h11;
        i2         = 8'h22;

        // Reset with a request present must not accept anything.
        cycles(2);
        chk("reset_output", {24'd0, result}, 32'h00);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        cycles(1);

        // Single-cycle ALU ops, latency 1.
        issue(4'd0, 8'hF0, 8'h20, {1'b0, 8'h10}, w);
        chk("add_latency", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'h10});
        issue(4'd1, 8'h05, 8'h07, {1'b0, 8'hFE}, w);
        chk("b2b_sub", w, 0);
        issue(4'd3, 8'h81, 8'h09, {1'b0, 8'h03}, w);
        chk("b2b_rotl", w, 0);
        issue(4'd5, 8'h10, 8'h11, {1'b0, 8'h10}, w);
        issue(4'd4, 8'h81, 8'h01, {1'b0, 8'hC0}, w);
        issue(4'd2, 8'h5A, 8'hFF, {1'b0, 8'hA5}, w);
        issue(4'd12, 8'h12, 8'h34, {1'b1, 8'h00}, w);
        chk("reserved_err", {23'd0, err, result}, {23'd0, 1'b1, 8'h00});

        // Key load, a reserved op that must leave the key alone, then ENC timing.
        issue(4'd6, 8'h00, 8'h01, {1'b0, 8'h01}, w);
        issue(4'd15, 8'h00, 8'h77, {1'b1, 8'h00}, w);
        issue(4'd7, 8'h10, 8'h00, {1'b0, 8'h24}, w);
        for (int n = 0; n < 4; n++) begin
            chk("enc_busy", {30'd0, busy, out_valid}, {30'd0, 1'b1, 1'b0});
            cycles(1);
        end
        chk("enc_done", {22'd0, busy, out_valid, result}, {22'd0, 1'b0, 1'b1, 8'h24});
        issue(4'd8, 8'h24, 8'h00, {1'b0, 8'h10}, w);
        cycles(5);

        // Backpressure: result held, no accept, then same-cycle accept on release.
        ready_mode = 0;
        cycles(1);
        issue(4'd0, 8'h33, 8'h44, {1'b0, 8'h77}, w);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {22'd0, in_ready, out_valid, result}, {22'd0, 1'b0, 1'b1, 8'h77});
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        issue(4'd2, 8'h0F, 8'hF0, {1'b0, 8'hFF}, w);
        chk("bp_release_accept", w, 0);
        cycles(2);

        // Reset two cycles into an ENC (key is 1 here): result dropped, key cleared.
        issue(4'd7, 8'h10, 8'h00, {1'b0, 8'h24}, w);
        cycles(2);
        chk("mid_enc_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        cycles(1);
        void'(sb.pop_back());
        rst = 1'b0;
        chk("abort_state", {30'd0, busy, out_valid}, 32'd0);
        cycles(6);
        chk("abort_no_result", {31'd0, out_valid}, 32'd0);
        issue(4'd7, 8'h10, 8'h00, {1'b0, 8'h02}, w);
        cycles(6);

        // Random keys/plaintexts with throttling on both sides.
        ready_mode = 2;
        for (int n = 0; n < 1000; n++) begin
            k = 8'($urandom);
            p = 8'($urandom);
            c = enc_model(p, k);
            cycles($urandom_range(0, 2));
            issue(4'd6, 8'($urandom), k, {1'b0, k}, w);
            cycles($urandom_range(0, 2));
            issue(4'd7, p, 8'($urandom), {1'b0, c}, w);
            cycles($urandom_range(0, 2));
            issue(4'd8, c, 8'($urandom), {1'b0, dec_model(c, k)}, w);
        end

        ready_mode = 1;
        begin
            int t;
            t = 0;
            while (sb.size() != 0 && t < 5000) begin
                cycles(1);
                t++;
            end
        end
        chk("drain", sb.size(), 0);
        cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
